// File: rtl/cpu_bus_master_pkg.sv
// cpu_bus_master_pkg
// Shared bus-1 definitions for the CPU-side bus master: bus widths,
// C1 command/response codes, master FSM state codes and small command
// helpers. Everything that talks to bus 1 imports this package so the
// codes and widths exist in exactly one place.
//
// Note: C1 is only 3 bits wide but carries nine names. C1_RESPONSE shares
// its code with C1_WRITE32. This is unambiguous because only the master
// drives commands (SEND1/SEND2) and only the cache drives responses
// (while the master is in WAIT/RECV2).
package cpu_bus_master_pkg;

  // Bus widths
  localparam int ADDR1_BUS_SIZE    = 15;
  localparam int DATA1_BUS_SIZE    = 16;
  localparam int CTR1_BUS_SIZE     = 3;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int CPU_ADDR_SIZE     = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;
  localparam int CPU_DATA_SIZE     = 2 * DATA1_BUS_SIZE;

  // C1 command / response codes
  localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

  // Master FSM states
  localparam int STATE_SIZE = 3;
  localparam logic [STATE_SIZE-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_SIZE-1:0] ST_SEND1 = 3'd1;
  localparam logic [STATE_SIZE-1:0] ST_SEND2 = 3'd2;
  localparam logic [STATE_SIZE-1:0] ST_TURN  = 3'd3;
  localparam logic [STATE_SIZE-1:0] ST_WAIT  = 3'd4;
  localparam logic [STATE_SIZE-1:0] ST_RECV2 = 3'd5;
  localparam logic [STATE_SIZE-1:0] ST_DONE  = 3'd6;

  function automatic logic cmd_is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic cmd_is_read(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  // Low half of read data as it lands in the response register: READ8 keeps
  // only the addressed byte, wider reads keep the whole first data beat.
  function automatic logic [CPU_DATA_SIZE-1:0] read_low_extend(
      input logic [CTR1_BUS_SIZE-1:0]  cmd,
      input logic [DATA1_BUS_SIZE-1:0] data);
    logic [CPU_DATA_SIZE-1:0] result;
    result = '0;
    if (cmd == C1_READ8) begin
      result[7:0] = data[7:0];
    end else begin
      result[DATA1_BUS_SIZE-1:0] = data;
    end
    return result;
  endfunction

endpackage

// File: rtl/cpu_bus_master_bus1_driver.sv
// cpu_bus_master_bus1_driver
// Tri-state drivers for the three bus-1 lines. Each line has a registered
// value and a registered output enable, loaded every CLK edge with the value
// the master wants on the bus for the coming cycle. RESET releases all lines
// immediately (combinationally) and clears the enables at the edge.
//
// Ports:
//   CLK, RESET                         clock, synchronous active-high reset
//   a1_next/a1_oe_next                 next A1 value / drive enable
//   d1_next/d1_oe_next                 next D1 value / drive enable
//   c1_next/c1_oe_next                 next C1 value / drive enable
//   d1_in, c1_in                       sample taps of the resolved D1/C1 lines
//   A1_WIRE, D1_WIRE, C1_WIRE          bus 1 tri-state lines
module cpu_bus_master_bus1_driver
  import cpu_bus_master_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR1_BUS_SIZE-1:0] a1_next,
  input  logic                      a1_oe_next,
  input  logic [DATA1_BUS_SIZE-1:0] d1_next,
  input  logic                      d1_oe_next,
  input  logic [CTR1_BUS_SIZE-1:0]  c1_next,
  input  logic                      c1_oe_next,
  output logic [DATA1_BUS_SIZE-1:0] d1_in,
  output logic [CTR1_BUS_SIZE-1:0]  c1_in,
  inout  wire  [ADDR1_BUS_SIZE-1:0] A1_WIRE,
  inout  wire  [DATA1_BUS_SIZE-1:0] D1_WIRE,
  inout  wire  [CTR1_BUS_SIZE-1:0]  C1_WIRE
);

  logic [ADDR1_BUS_SIZE-1:0] a1_q;
  logic [DATA1_BUS_SIZE-1:0] d1_q;
  logic [CTR1_BUS_SIZE-1:0]  c1_q;
  logic                      a1_oe;
  logic                      d1_oe;
  logic                      c1_oe;
  logic                      a1_drive;
  logic                      d1_drive;
  logic                      c1_drive;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a1_q  <= '0;
      d1_q  <= '0;
      c1_q  <= '0;
      a1_oe <= 1'b0;
      d1_oe <= 1'b0;
      c1_oe <= 1'b0;
    end else begin
      a1_q  <= a1_next;
      d1_q  <= d1_next;
      c1_q  <= c1_next;
      a1_oe <= a1_oe_next;
      d1_oe <= d1_oe_next;
      c1_oe <= c1_oe_next;
    end
  end

  // Gating with RESET releases the bus within the reset cycle itself instead
  // of waiting for the clearing edge.
  assign a1_drive = a1_oe && !RESET;
  assign d1_drive = d1_oe && !RESET;
  assign c1_drive = c1_oe && !RESET;

  assign A1_WIRE = a1_drive ? a1_q : 'z;
  assign D1_WIRE = d1_drive ? d1_q : 'z;
  assign C1_WIRE = c1_drive ? c1_q : 'z;

  assign d1_in = D1_WIRE;
  assign c1_in = C1_WIRE;

endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master
// CPU-side initiator for bus 1 (A1/D1/C1). Takes one request at a time on a
// valid/ready port, sends command + tag/set address + low write data, then
// command + offset + high write data, turns the bus around to the cache and
// waits for C1_RESPONSE, collecting one (or two, for READ32) data beats.
// Completion is a one-cycle resp_valid pulse.
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT-state watchdog limit (only with the macro below)
// Configuration macro:
//   CPU_BUS_MASTER_TIMEOUT_EN  enables the response watchdog; when it fires
//                              the request completes with resp_error=1 and
//                              resp_rdata=0. Without it the master waits
//                              forever and resp_error is constant 0.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_cmd           C1_* command code; C1_NOP requests are dropped
//   req_addr          19-bit byte address
//   req_wdata         32-bit little-endian write data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        read data, zero-extended for READ8/16, 0 otherwise
//   resp_error        watchdog abort flag, valid with resp_valid
//   A1/D1/C1_WIRE     bus 1 tri-state lines
module cpu_bus_master
  import cpu_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CTR1_BUS_SIZE-1:0]  req_cmd,
  input  logic [CPU_ADDR_SIZE-1:0]  req_addr,
  input  logic [CPU_DATA_SIZE-1:0]  req_wdata,
  output logic                      resp_valid,
  output logic [CPU_DATA_SIZE-1:0]  resp_rdata,
  output logic                      resp_error,
  inout  wire  [ADDR1_BUS_SIZE-1:0] A1_WIRE,
  inout  wire  [DATA1_BUS_SIZE-1:0] D1_WIRE,
  inout  wire  [CTR1_BUS_SIZE-1:0]  C1_WIRE
);

  logic [STATE_SIZE-1:0]     state;
  logic [STATE_SIZE-1:0]     state_next;
  logic                      accept;
  logic                      response_seen;
  logic                      timeout_hit;

  logic [CTR1_BUS_SIZE-1:0]  cmd_q;
  logic [CPU_ADDR_SIZE-1:0]  addr_q;
  logic [CPU_DATA_SIZE-1:0]  wdata_q;
  logic [CPU_DATA_SIZE-1:0]  rdata_q;
  logic                      error_q;

  logic [CTR1_BUS_SIZE-1:0]  cur_cmd;
  logic [CPU_ADDR_SIZE-1:0]  cur_addr;
  logic [CPU_DATA_SIZE-1:0]  cur_wdata;

  logic [ADDR1_BUS_SIZE-1:0] a1_next;
  logic                      a1_oe_next;
  logic [DATA1_BUS_SIZE-1:0] d1_next;
  logic                      d1_oe_next;
  logic [CTR1_BUS_SIZE-1:0]  c1_next;
  logic                      c1_oe_next;
  logic [DATA1_BUS_SIZE-1:0] d1_in;
  logic [CTR1_BUS_SIZE-1:0]  c1_in;

  cpu_bus_master_bus1_driver u_bus1_driver (
    .CLK        (CLK),
    .RESET      (RESET),
    .a1_next    (a1_next),
    .a1_oe_next (a1_oe_next),
    .d1_next    (d1_next),
    .d1_oe_next (d1_oe_next),
    .c1_next    (c1_next),
    .c1_oe_next (c1_oe_next),
    .d1_in      (d1_in),
    .c1_in      (c1_in),
    .A1_WIRE    (A1_WIRE),
    .D1_WIRE    (D1_WIRE),
    .C1_WIRE    (C1_WIRE)
  );

`ifdef CPU_BUS_MASTER_TIMEOUT_EN
  // Counter is at least 8 bits wide and grows if the limit needs more.
  localparam int TO_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W     = (TO_RAW_W > 8) ? TO_RAW_W : 8;

  logic [TO_W-1:0] wait_cnt;

  // Counts WAIT cycles; restarts whenever the FSM is anywhere else.
  always_ff @(posedge CLK) begin
    if (RESET || (state != ST_WAIT)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a response.
  assign timeout_hit = (state == ST_WAIT) && !response_seen &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build; the parameter stays so both builds share
  // one parameter list, and it folds to a constant 0 here.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // While IDLE the request inputs feed the SEND1 drive values directly,
  // since the latch registers only load at the same edge.
  assign cur_cmd   = (state == ST_IDLE) ? req_cmd   : cmd_q;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;

  assign response_seen = (c1_in == C1_RESPONSE);

  // Next-state logic. Unexpected C1 codes in WAIT are treated like NOP.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && (req_cmd != C1_NOP)) begin
          accept     = 1'b1;
          state_next = ST_SEND1;
        end
      end
      ST_SEND1: state_next = ST_SEND2;
      ST_SEND2: state_next = ST_TURN;
      ST_TURN:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (response_seen) begin
          state_next = (cmd_q == C1_READ32) ? ST_RECV2 : ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_RECV2: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bus values for the coming cycle are derived from the state being entered
  // so they appear on the lines together with that state.
  always_comb begin
    a1_next    = '0;
    a1_oe_next = 1'b0;
    d1_next    = '0;
    d1_oe_next = 1'b0;
    c1_next    = C1_NOP;
    c1_oe_next = 1'b0;
    case (state_next)
      ST_IDLE: begin
        c1_oe_next = 1'b1;
      end
      ST_SEND1: begin
        c1_next    = cur_cmd;
        c1_oe_next = 1'b1;
        a1_next    = cur_addr[CPU_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        a1_oe_next = 1'b1;
        d1_next    = cur_wdata[DATA1_BUS_SIZE-1:0];
        d1_oe_next = cmd_is_write(cur_cmd);
      end
      ST_SEND2: begin
        c1_next    = cur_cmd;
        c1_oe_next = 1'b1;
        a1_next    = {{(ADDR1_BUS_SIZE - CACHE_OFFSET_SIZE){1'b0}},
                      cur_addr[CACHE_OFFSET_SIZE-1:0]};
        a1_oe_next = 1'b1;
        d1_next    = cur_wdata[CPU_DATA_SIZE-1:DATA1_BUS_SIZE];
        d1_oe_next = (cur_cmd == C1_WRITE32);
      end
      default: begin
        c1_oe_next = 1'b0;
      end
    endcase
  end

  // State, request latch and response capture. rdata/error are cleared at
  // accept so writes, invalidates and timeouts complete with rdata=0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cmd_q   <= C1_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cmd_q   <= req_cmd;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        error_q <= 1'b0;
      end
      if ((state == ST_WAIT) && response_seen && cmd_is_read(cmd_q)) begin
        rdata_q <= read_low_extend(cmd_q, d1_in);
      end
      if (timeout_hit) begin
        error_q <= 1'b1;
      end
      if (state == ST_RECV2) begin
        rdata_q[CPU_DATA_SIZE-1:DATA1_BUS_SIZE] <= d1_in;
      end
    end
  end

  assign req_ready  = (state == ST_IDLE) && !RESET;
  assign resp_valid = (state == ST_DONE) && !RESET;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master
// Self-checking bench for cpu_bus_master. A cache-side responder inside the
// bench answers each request after a random number of WAIT cycles; expected
// bus contents, read data and latency come from a transaction-level model.
// Works with or without CPU_BUS_MASTER_TIMEOUT_EN (watchdog set to 8 cycles).
module tb_cpu_bus_master;
  import cpu_bus_master_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic                      CLK = 1'b0;
  logic                      RESET = 1'b1;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [CTR1_BUS_SIZE-1:0]  req_cmd = '0;
  logic [CPU_ADDR_SIZE-1:0]  req_addr = '0;
  logic [CPU_DATA_SIZE-1:0]  req_wdata = '0;
  logic                      resp_valid;
  logic [CPU_DATA_SIZE-1:0]  resp_rdata;
  logic                      resp_error;
  wire  [ADDR1_BUS_SIZE-1:0] A1_WIRE;
  wire  [DATA1_BUS_SIZE-1:0] D1_WIRE;
  wire  [CTR1_BUS_SIZE-1:0]  C1_WIRE;

  // Cache-side responder drive
  logic [CTR1_BUS_SIZE-1:0]  rsp_c1 = '0;
  logic                      rsp_c1_oe = 1'b0;
  logic [DATA1_BUS_SIZE-1:0] rsp_d1 = '0;
  logic                      rsp_d1_oe = 1'b0;

  assign C1_WIRE = rsp_c1_oe ? rsp_c1 : 'z;
  assign D1_WIRE = rsp_d1_oe ? rsp_d1 : 'z;

  int error_count = 0;
  int check_count = 0;
  int cycle_count = 0;

  cpu_bus_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .A1_WIRE    (A1_WIRE),
    .D1_WIRE    (D1_WIRE),
    .C1_WIRE    (C1_WIRE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle_count <= cycle_count + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transaction-level model of the completion data.
  function automatic logic [31:0] model_rdata(input logic [2:0] cmd,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
    case (cmd)
      C1_READ8:  return {24'h0, lo[7:0]};
      C1_READ16: return {16'h0, lo};
      C1_READ32: return {hi, lo};
      default:   return 32'h0;
    endcase
  endfunction

  function automatic bit model_is_write(input logic [2:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks that all three lines are released by the master.
  task automatic checkReleased(input string tag);
    checkOutput({tag, "_a1_drive"}, 32'(dut.u_bus1_driver.a1_drive), 32'd0);
    checkOutput({tag, "_d1_drive"}, 32'(dut.u_bus1_driver.d1_drive), 32'd0);
    checkOutput({tag, "_c1_drive"}, 32'(dut.u_bus1_driver.c1_drive), 32'd0);
  endtask

  // One complete transaction: request, bus-phase checks, responder, completion.
  // delay = WAIT cycles filled with non-response codes before RESPONSE;
  // silent = responder never answers.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [18:0] addr,
                               input logic [31:0] wdata, input int delay,
                               input logic [15:0] lo, input logic [15:0] hi,
                               input bit silent);
    int  accept_cycle;
    int  exp_latency;
    bit  exp_resp;
    bit  exp_error;
    bit  got;
    for (int i = 0; i < 10 && !req_ready; i++) tick();
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);

    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid    = 1'b0;
    req_cmd      = $urandom_range(0, 7);
    accept_cycle = cycle_count;

    // SEND1
    checkOutput("send1_c1_drive", 32'(dut.u_bus1_driver.c1_drive), 32'd1);
    checkOutput("send1_c1", 32'(C1_WIRE), 32'(cmd));
    checkOutput("send1_a1", 32'(A1_WIRE), 32'(addr >> 4));
    if (model_is_write(cmd)) begin
      checkOutput("send1_d1", 32'(D1_WIRE), 32'(wdata & 32'hFFFF));
    end else begin
      checkOutput("send1_d1_drive", 32'(dut.u_bus1_driver.d1_drive), 32'd0);
    end
    checkOutput("send1_ready", 32'(req_ready), 32'd0);
    tick();

    // SEND2
    checkOutput("send2_c1", 32'(C1_WIRE), 32'(cmd));
    checkOutput("send2_a1", 32'(A1_WIRE), 32'(addr % 16));
    if (cmd == C1_WRITE32) begin
      checkOutput("send2_d1", 32'(D1_WIRE), wdata >> 16);
    end else begin
      checkOutput("send2_d1_drive", 32'(dut.u_bus1_driver.d1_drive), 32'd0);
    end
    tick();

    // TURN
    checkReleased("turn");
    checkOutput("turn_valid", 32'(resp_valid), 32'd0);
    tick();

    // WAIT: filler codes first, then the response beats
    for (int i = 0; i < delay; i++) begin
      rsp_c1    = 3'($urandom_range(0, 6));
      rsp_c1_oe = 1'b1;
      checkOutput("wait_valid", 32'(resp_valid), 32'd0);
      tick();
    end
    if (!silent) begin
      rsp_c1    = C1_RESPONSE;
      rsp_c1_oe = 1'b1;
      rsp_d1    = lo;
      rsp_d1_oe = 1'b1;
      tick();
      if (cmd == C1_READ32) begin
        rsp_d1 = hi;
        tick();
      end
    end
    rsp_c1_oe = 1'b0;
    rsp_d1_oe = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end

`ifdef CPU_BUS_MASTER_TIMEOUT_EN
    exp_resp    = 1'b1;
    exp_error   = silent;
    exp_latency = silent ? (4 + TB_TIMEOUT) : (5 + delay + ((cmd == C1_READ32) ? 1 : 0));
`else
    exp_resp    = !silent;
    exp_error   = 1'b0;
    exp_latency = 5 + delay + ((cmd == C1_READ32) ? 1 : 0);
`endif
    checkOutput("resp_seen", 32'(got), 32'(exp_resp));
    if (got) begin
      checkOutput("latency", 32'(cycle_count - accept_cycle + 1), 32'(exp_latency));
      checkOutput("rdata", resp_rdata, silent ? 32'h0 : model_rdata(cmd, lo, hi));
      checkOutput("error", 32'(resp_error), 32'(exp_error));
      checkReleased("done");
      tick();
      checkOutput("pulse_end", 32'(resp_valid), 32'd0);
      checkOutput("b2b_ready", 32'(req_ready), 32'd1);
    end else begin
      // Stuck in WAIT by design; reset to recover.
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
    end
  endtask

  // Reset arrives while the master waits for a response.
  task automatic resetDuringWait();
    int pulses;
    for (int i = 0; i < 10 && !req_ready; i++) tick();
    req_valid = 1'b1;
    req_cmd   = C1_READ16;
    req_addr  = 19'h0ABCD;
    req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b1;
    #1;
    checkReleased("rst_wait");
    checkOutput("rst_wait_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("rst_wait_valid", 32'(resp_valid), 32'd0);
    RESET = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    checkOutput("rst_no_resp", 32'(pulses), 32'd0);
  endtask

  initial begin
    int pulses;
    $display("[TB] start");

    // Reset held two cycles
    tick();
    checkReleased("reset1");
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    tick();
    checkReleased("reset2");
    checkOutput("reset_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_error", 32'(resp_error), 32'd0);
    RESET = 1'b0;
    tick();
    checkOutput("idle_c1_drive", 32'(dut.u_bus1_driver.c1_drive), 32'd1);
    checkOutput("idle_c1", 32'(C1_WIRE), 32'(C1_NOP));
    checkOutput("idle_ready", 32'(req_ready), 32'd1);

    // Directed cases
    applyStimulus(C1_READ32, 19'h12345, 32'h0, 0, 16'hBEEF, 16'hDEAD, 1'b0);
    applyStimulus(C1_WRITE32, 19'h00010, 32'hCAFEF00D, 0, 16'h1111, 16'h2222, 1'b0);
    applyStimulus(C1_READ8, 19'h00007, 32'h0, 1, 16'hABCD, 16'h0, 1'b0);
    applyStimulus(C1_INVALIDATE_LINE, 19'h0, 32'h0, 2, 16'h5555, 16'h0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      applyStimulus(3'($urandom_range(1, 7)), 19'($urandom()), $urandom(),
                    int'($urandom_range(0, 4)), 16'($urandom()), 16'($urandom()), 1'b0);
    end

    // Reset mid-transaction, then a clean request
    resetDuringWait();
    applyStimulus(C1_WRITE16, 19'h7FFFF, 32'h1234ABCD, 0, 16'h0, 16'h0, 1'b0);

    // NOP request is dropped
    req_valid = 1'b1;
    req_cmd   = C1_NOP;
    req_addr  = 19'h00123;
    tick();
    req_valid = 1'b0;
    checkOutput("nop_ready", 32'(req_ready), 32'd1);
    checkOutput("nop_c1", 32'(C1_WIRE), 32'(C1_NOP));
    checkOutput("nop_a1_drive", 32'(dut.u_bus1_driver.a1_drive), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    checkOutput("nop_no_resp", 32'(pulses), 32'd0);

    // Silent responder: watchdog completion or endless wait
    applyStimulus(C1_READ16, 19'h00400, 32'h0, 0, 16'h0, 16'h0, 1'b1);
    applyStimulus(C1_READ16, 19'h00404, 32'h0, 0, 16'h8001, 16'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Synthesizable CPU-side initiator for bus 1 (A1/D1/C1), the cache's upstream tri-state bus. Accepts one request at a time on a valid/ready port, serializes command, address and write data onto bus 1, hands ownership to the cache, then collects C1_RESPONSE and read data. It replaces hand-sequenced bus stimulus in benches and is the bus interface of the future CPU model.

## Interface
- ADDR1_BUS_SIZE, 15: A1 width; carries tag+set in cycle 1, offset in cycle 2.
- DATA1_BUS_SIZE, 16: D1 width.
- CTR1_BUS_SIZE, 3: C1 width.
- CACHE_OFFSET_SIZE, 4: byte-offset bits; full address = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE = 19 bits.
- TIMEOUT_CYCLES, 255: response watchdog limit (used only with CPU_BUS_MASTER_TIMEOUT_EN).
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle, accepts request this cycle.
- req_cmd  in  CTR1_BUS_SIZE  C1_* command code.
- req_addr  in  19  byte address.
- req_wdata  in  32  write data, little-endian, low bytes used for WRITE8/16.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data, zero-extended for READ8/16; 0 for writes/invalidate.
- resp_error  out  1  valid with resp_valid; watchdog abort.
- A1_WIRE  inout  ADDR1_BUS_SIZE  bus 1 address.
- D1_WIRE  inout  DATA1_BUS_SIZE  bus 1 data.
- C1_WIRE  inout  CTR1_BUS_SIZE  bus 1 command/response.

## Operation
- All state changes and bus drive updates on CLK posedge; responder samples lines at the following posedge.
- States: IDLE, SEND1, SEND2, TURN, WAIT, RECV2, DONE.
- IDLE: req_ready=1; C1=C1_NOP, A1/D1=z. req_valid with cmd C1_NOP is dropped (no bus activity, no response). Otherwise latch cmd/addr/wdata -> SEND1.
- SEND1: C1=cmd, A1=addr[18:4], D1=wdata[15:0] for WRITE*, else z -> SEND2.
- SEND2: C1=cmd, A1=zero-extended addr[3:0], D1=wdata[31:16] for WRITE32, else z -> TURN.
- TURN: A1/D1/C1=z (ownership to cache) -> WAIT.
- WAIT: lines z; C1 of NOP or z keeps waiting. On C1==C1_RESPONSE: capture D1 into rdata[15:0] for READ*; READ32 -> RECV2, else -> DONE.
- RECV2: capture D1 into rdata[31:16] -> DONE.
- DONE: lines z (cache releasing), resp_valid=1 for this cycle -> IDLE.
- READ8 keeps rdata[7:0], zeroes [31:8]; READ16 keeps [15:0].
- req_valid while not IDLE is ignored; no queueing.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, A1/D1/C1=z while RESET high; IDLE drives C1_NOP from first cycle after RESET falls.
- RESET mid-transaction: immediate return to IDLE, latched request discarded, no resp_valid; bus released (z) during reset cycle.
- Request accepted at edge N: command on C1 at N+1 and N+2, z from N+3.
- Minimum latency accept->resp_valid: 5 cycles (response in first WAIT cycle, non-READ32); READ32 adds 1.
- Back-to-back: next request accepted in the cycle after DONE.
- C1 value other than NOP/z/C1_RESPONSE in WAIT: treated as still waiting.

## Configuration
- CPU_BUS_MASTER_TIMEOUT_EN defined: 8-bit-plus counter runs in WAIT; after TIMEOUT_CYCLES cycles without C1_RESPONSE go DONE with resp_error=1, resp_rdata=0.
- Not defined: WAIT indefinitely; resp_error tied 0; port list unchanged.

## Structure
- Bus widths, C1_* codes (C1_NOP, READ8/16/32, INVALIDATE_LINE, WRITE8/16/32, C1_RESPONSE) and state enum in the shared parameters/commands definitions; no local copies.
- One sub-module: bus1_driver — per-line tri-state drive from registered value + enable, plus sample taps.

## Test plan
- Reset: RESET high 2 cycles -> all lines z, req_ready=0; release -> C1=C1_NOP, req_ready=1.
- READ32 addr 0x12345, responder returns RESPONSE with D1=0xBEEF then 0xDEAD -> A1=0x1234 then 0x5, resp_rdata=0xDEADBEEF, resp_valid 6 cycles after accept.
- WRITE32 addr 0x00010, wdata 0xCAFEF00D -> D1=0xF00D in SEND1, 0xCAFE in SEND2, resp_rdata=0.
- READ8 with D1=0xABCD at response -> resp_rdata=0x000000CD; INVALIDATE_LINE addr 0 -> D1 z throughout, resp_valid after RESPONSE.
- RESET asserted in WAIT -> no resp_valid, next request starts clean SEND1.
- Macro on, TIMEOUT_CYCLES=8, responder silent -> resp_valid with resp_error=1 after 8 WAIT cycles; macro off -> no response.
